ahbl_master_mux: RTL and testbench
==================================

# ahbl_master_mux

Two-master AHB-Lite master multiplexer: the initiator-side counterpart of the address-decoding splitter. It joins a CPU port (M0) and a DMA/debug port (M1) onto the single AHB-Lite bus that feeds the splitter. Arbitration happens only at transfer boundaries, so no address phase is ever buffered or dropped. The non-granted master is stalled with HREADY low.

## Interface
Parameters: none.

Ports:
- HCLK  in  1  bus clock. One clock domain.
- HRESETn  in  1  reset. Synchronous, active-low.
- M0_HADDR / M1_HADDR  in  32  master address.
- M0_HTRANS / M1_HTRANS  in  2  master transfer type; bit 1 set means NONSEQ/SEQ (request).
- M0_HWRITE / M1_HWRITE  in  1  write flag.
- M0_HSIZE / M1_HSIZE  in  3  transfer size.
- M0_HWDATA / M1_HWDATA  in  32  write data, data phase.
- M0_HREADY / M1_HREADY  out  1  per-master ready.
- M0_HRDATA / M1_HRDATA  out  32  read data, a copy of bus HRDATA.
- HADDR, HTRANS, HWRITE, HSIZE  out  32/2/1/3  bus address phase, taken from the granted master.
- HWDATA  out  32  bus write data, taken from the data-phase owner.
- HREADY  in  1  bus ready, from the splitter.
- HRDATA  in  32  bus read data, from the splitter.
- HMASTER  out  1  current grant: 0 = M0, 1 = M1.

## Operation
- State registers:
  - grant (1 bit): selects the master whose address phase is routed to the bus.
  - downer (1 bit): the master owning the current data phase.
- Address mux: the bus HADDR, HTRANS, HWRITE and HSIZE come combinationally from Mgrant. HMASTER = grant.
- Data mux: HWDATA = downer ? M1_HWDATA : M0_HWDATA.
- Per-master HREADY:
  - Mx granted: Mx_HREADY = HREADY.
  - Mx not granted: Mx_HREADY = ~Mx_HTRANS[1]. A requesting non-granted master is held in wait; its address phase is frozen by AHB-Lite rules.
- downer update: on a rising edge with HREADY=1, downer <= grant.
- Arbitration point: a rising edge with HREADY=1 and Mgrant_HTRANS[1]=0 (the holder is issuing IDLE).
  - If Mother_HTRANS[1]=1, then grant <= other.
  - Otherwise the parking rule applies (see Configuration).
- No switch ever occurs while the holder drives NONSEQ or SEQ, so bursts are never split. A holder that never idles starves the other master; this is a documented system constraint.
- Simultaneous request by both masters at the arbitration point: the non-holder wins, because the holder is idle by definition.

## Timing
- Granted master: zero added latency; the bus address phase is the same cycle as the master address phase.
- Switch cost: exactly one cycle. The holder's IDLE is accepted at edge N; the new master's address is on the bus in cycle N+1; its HREADY is low during cycle N and equals bus HREADY from N+1.
- Bus HREADY low: grant and downer both hold. The non-granted master stays stalled.
- Reset (synchronous, sampled at the HCLK edge):
  - grant=0 and downer=0.
  - After reset: HMASTER=0; bus address signals mirror M0; M1_HREADY = ~M1_HTRANS[1].
  - Reset asserted mid-transfer aborts ownership immediately at that edge; the slaves are reset by the same HRESETn.

## Configuration
- Macro AHBL_MASTER_MUX_PARK_EN.
- Defined: at an arbitration point where neither master requests, grant <= 0. The bus parks on M0, so a later M0 request has zero switch latency.
- Undefined: grant holds its last value when neither master requests (park on last holder).

## Test plan
- Reset, then M0 issues a NONSEQ read to 0x0000_0010 with HREADY=1.
  - Required: bus HADDR=0x0000_0010 in the same cycle, M0_HREADY=1, HMASTER=0, M1_HREADY=1 (M1 idle).
- M0 runs a 4-beat SEQ burst while M1 issues NONSEQ to 0x2000_0000 at beat 2.
  - Required: M1_HREADY=0 until M0 drives IDLE; grant flips at that edge; the next cycle shows HADDR=0x2000_0000, HMASTER=1, M1_HREADY=HREADY.
- M1 write of 0xCAFE_F00D; the bus holds HREADY=0 for 2 data-phase cycles while M0 requests.
  - Required: HWDATA=0xCAFE_F00D for all 3 data cycles; M0_HREADY=0 throughout; grant unchanged until HREADY=1 and M1 is IDLE.
- Both masters IDLE after an M1 transfer.
  - With AHBL_MASTER_MUX_PARK_EN: HMASTER becomes 0 one edge later.
  - Without it: HMASTER stays 1 and a subsequent M0 NONSEQ sees one wait cycle.
- HRESETn driven low for one edge while M1 is granted mid-burst.
  - Required: HMASTER=0 and downer=0 after that edge, and bus signals mirror M0.

Source files
------------

// File: rtl/ahbl_master_mux.sv
// Two-master AHB-Lite master multiplexer: joins M0 (CPU) and M1 (DMA/debug) onto one bus.
// Arbitration only happens when the current holder issues IDLE with the bus ready, so bursts
// are never split and no address phase is buffered. The non-granted master waits on HREADY low.
// Optional feature: define AHBL_MASTER_MUX_PARK_EN to park the bus on M0 when nobody requests;
// otherwise the bus parks on the last holder.
module ahbl_master_mux (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [31:0] M0_HWDATA,
  output logic        M0_HREADY,
  output logic [31:0] M0_HRDATA,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [31:0] M1_HWDATA,
  output logic        M1_HREADY,
  output logic [31:0] M1_HRDATA,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  output logic        HMASTER
);

  // grant_q selects the address-phase master; downer_q owns the current data phase.
  logic grant_q, grant_d;
  logic downer_q, downer_d;
  logic m0_req, m1_req;
  logic hold_req, other_req;

  assign m0_req    = M0_HTRANS[1];
  assign m1_req    = M1_HTRANS[1];
  assign hold_req  = grant_q ? m1_req : m0_req;
  assign other_req = grant_q ? m0_req : m1_req;

  // Address-phase mux from the granted master, data mux from the data-phase owner.
  always_comb begin
    HADDR   = grant_q ? M1_HADDR  : M0_HADDR;
    HTRANS  = grant_q ? M1_HTRANS : M0_HTRANS;
    HWRITE  = grant_q ? M1_HWRITE : M0_HWRITE;
    HSIZE   = grant_q ? M1_HSIZE  : M0_HSIZE;
    HWDATA  = downer_q ? M1_HWDATA : M0_HWDATA;
    HMASTER = grant_q;
  end

  // Granted master sees bus ready; a requesting non-granted master is held in wait.
  always_comb begin
    M0_HREADY = grant_q ? ~m0_req : HREADY;
    M1_HREADY = grant_q ? HREADY  : ~m1_req;
    M0_HRDATA = HRDATA;
    M1_HRDATA = HRDATA;
  end

  // Next grant/owner: only move on an accepted edge, and only switch when the holder idles.
  always_comb begin
    grant_d  = grant_q;
    downer_d = downer_q;
    if (HREADY) begin
      downer_d = grant_q;
      if (!hold_req) begin
        if (other_req) begin
          grant_d = ~grant_q;
        end else begin
`ifdef AHBL_MASTER_MUX_PARK_EN
          grant_d = 1'b0;
`else
          grant_d = grant_q;
`endif
        end
      end
    end
  end

  // State registers with synchronous active-low reset; reset drops ownership immediately.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      grant_q  <= 1'b0;
      downer_q <= 1'b0;
    end else begin
      grant_q  <= grant_d;
      downer_q <= downer_d;
    end
  end

endmodule

// File: tb/tb_ahbl_master_mux.sv
// Self-checking bench for ahbl_master_mux: directed vectors, a behavioural ownership model
// compared on every cycle, and literal expectations for the key scenarios.
module tb_ahbl_master_mux;

  logic        HCLK;
  logic        HRESETn;
  logic [31:0] M0_HADDR, M1_HADDR;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic        M0_HWRITE, M1_HWRITE;
  logic [2:0]  M0_HSIZE, M1_HSIZE;
  logic [31:0] M0_HWDATA, M1_HWDATA;
  logic        M0_HREADY, M1_HREADY;
  logic [31:0] M0_HRDATA, M1_HRDATA;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HMASTER;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  ahbl_master_mux dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .M0_HADDR  (M0_HADDR),
    .M0_HTRANS (M0_HTRANS),
    .M0_HWRITE (M0_HWRITE),
    .M0_HSIZE  (M0_HSIZE),
    .M0_HWDATA (M0_HWDATA),
    .M0_HREADY (M0_HREADY),
    .M0_HRDATA (M0_HRDATA),
    .M1_HADDR  (M1_HADDR),
    .M1_HTRANS (M1_HTRANS),
    .M1_HWRITE (M1_HWRITE),
    .M1_HSIZE  (M1_HSIZE),
    .M1_HWDATA (M1_HWDATA),
    .M1_HREADY (M1_HREADY),
    .M1_HRDATA (M1_HRDATA),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HRDATA    (HRDATA),
    .HMASTER   (HMASTER)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Ownership model: who holds the address phase and who owns the data phase.
  logic       m_holder;
  logic       m_dphase;
  logic [1:0] req;
  assign req = {M1_HTRANS[1], M0_HTRANS[1]};

  // Holder changes only on an accepted edge where it is idle; data phase follows the holder.
  always @(posedge HCLK) begin
    if (!HRESETn) begin
      m_holder <= 1'b0;
      m_dphase <= 1'b0;
    end else if (HREADY) begin
      m_dphase <= m_holder;
      if (!req[m_holder]) begin
        if (req[!m_holder]) m_holder <= !m_holder;
`ifdef AHBL_MASTER_MUX_PARK_EN
        else m_holder <= 1'b0;
`endif
      end
    end
  end

  // Every-cycle comparison of all outputs against the model, sampled mid-cycle.
  always @(negedge HCLK) begin
    if (chk_en) begin
      chk("m_HADDR",   HADDR,  m_holder ? M1_HADDR  : M0_HADDR);
      chk("m_HTRANS",  {30'd0, HTRANS}, {30'd0, m_holder ? M1_HTRANS : M0_HTRANS});
      chk("m_HWRITE",  {31'd0, HWRITE}, {31'd0, m_holder ? M1_HWRITE : M0_HWRITE});
      chk("m_HSIZE",   {29'd0, HSIZE},  {29'd0, m_holder ? M1_HSIZE  : M0_HSIZE});
      chk("m_HWDATA",  HWDATA, m_dphase ? M1_HWDATA : M0_HWDATA);
      chk("m_HMASTER", {31'd0, HMASTER}, {31'd0, m_holder});
      chk("m_M0_HREADY", {31'd0, M0_HREADY}, {31'd0, (m_holder == 1'b0) ? HREADY : !req[0]});
      chk("m_M1_HREADY", {31'd0, M1_HREADY}, {31'd0, (m_holder == 1'b1) ? HREADY : !req[1]});
      chk("m_M0_HRDATA", M0_HRDATA, HRDATA);
      chk("m_M1_HRDATA", M1_HRDATA, HRDATA);
    end
  end

  // Read data changes every cycle so the copy paths are exercised.
  always @(posedge HCLK) HRDATA <= HRDATA + 32'h0101_0101;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic mid();
    @(negedge HCLK);
  endtask

  task automatic m0(input logic [1:0] t, input logic [31:0] a, input logic w);
    M0_HTRANS = t;
    M0_HADDR  = a;
    M0_HWRITE = w;
  endtask

  task automatic m1(input logic [1:0] t, input logic [31:0] a, input logic w);
    M1_HTRANS = t;
    M1_HADDR  = a;
    M1_HWRITE = w;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    HRESETn   = 1'b0;
    HREADY    = 1'b1;
    HRDATA    = 32'h1234_0000;
    M0_HADDR  = 32'h0;  M0_HTRANS = IDLE; M0_HWRITE = 1'b0; M0_HSIZE = 3'd2;
    M1_HADDR  = 32'h0;  M1_HTRANS = IDLE; M1_HWRITE = 1'b0; M1_HSIZE = 3'd1;
    M0_HWDATA = 32'h0000_AAAA;
    M1_HWDATA = 32'hBBBB_0000;

    // Reset state
    tick();
    chk_en = 1;
    mid();
    chk("rst_HMASTER", {31'd0, HMASTER}, 32'd0);
    chk("rst_M1_HREADY", {31'd0, M1_HREADY}, 32'd1);
    HRESETn = 1'b1;
    tick();

    // M0 NONSEQ read, zero latency
    m0(NONSEQ, 32'h0000_0010, 1'b0);
    mid();
    chk("t1_HADDR", HADDR, 32'h0000_0010);
    chk("t1_M0_HREADY", {31'd0, M0_HREADY}, 32'd1);
    chk("t1_HMASTER", {31'd0, HMASTER}, 32'd0);
    chk("t1_M1_HREADY", {31'd0, M1_HREADY}, 32'd1);
    tick();

    // M0 burst continues; M1 requests a write at beat 2 and is stalled
    m0(SEQ, 32'h0000_0014, 1'b0);
    m1(NONSEQ, 32'h2000_0000, 1'b1);
    mid();
    chk("t2_b2_M1_HREADY", {31'd0, M1_HREADY}, 32'd0);
    tick();
    m0(SEQ, 32'h0000_0018, 1'b0);
    mid();
    chk("t2_b3_M1_HREADY", {31'd0, M1_HREADY}, 32'd0);
    tick();
    m0(SEQ, 32'h0000_001C, 1'b0);
    mid();
    chk("t2_b4_HMASTER", {31'd0, HMASTER}, 32'd0);
    tick();
    m0(IDLE, 32'h0000_0000, 1'b0);
    mid();
    chk("t2_idle_M1_HREADY", {31'd0, M1_HREADY}, 32'd0);
    chk("t2_idle_HMASTER", {31'd0, HMASTER}, 32'd0);
    tick();

    // M1 address phase on bus; M0 now requests and waits
    m0(NONSEQ, 32'h0000_0040, 1'b0);
    mid();
    chk("t2_sw_HADDR", HADDR, 32'h2000_0000);
    chk("t2_sw_HMASTER", {31'd0, HMASTER}, 32'd1);
    chk("t2_sw_M1_HREADY", {31'd0, M1_HREADY}, 32'd1);
    chk("t3_a_M0_HREADY", {31'd0, M0_HREADY}, 32'd0);
    tick();

    // M1 write data phase, extended by two bus wait states
    m1(IDLE, 32'h0, 1'b0);
    M1_HWDATA = 32'hCAFE_F00D;
    HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) HREADY = 1'b1;
      mid();
      chk("t3_HWDATA", HWDATA, 32'hCAFE_F00D);
      chk("t3_M0_HREADY", {31'd0, M0_HREADY}, 32'd0);
      chk("t3_HMASTER", {31'd0, HMASTER}, 32'd1);
      tick();
    end
    mid();
    chk("t3_sw_HMASTER", {31'd0, HMASTER}, 32'd0);
    chk("t3_sw_HADDR", HADDR, 32'h0000_0040);
    chk("t3_sw_M0_HREADY", {31'd0, M0_HREADY}, 32'd1);
    tick();

    // One M1 read, then both idle: parking behaviour
    m0(IDLE, 32'h0, 1'b0);
    m1(NONSEQ, 32'h2000_0004, 1'b0);
    mid();
    chk("t4_M1_HREADY", {31'd0, M1_HREADY}, 32'd0);
    tick();
    mid();
    chk("t4_HMASTER", {31'd0, HMASTER}, 32'd1);
    chk("t4_HADDR", HADDR, 32'h2000_0004);
    tick();
    m1(IDLE, 32'h0, 1'b0);
    mid();
    chk("t4_idle_HMASTER", {31'd0, HMASTER}, 32'd1);
    tick();
    m0(NONSEQ, 32'h0000_0080, 1'b0);
    mid();
`ifdef AHBL_MASTER_MUX_PARK_EN
    chk("t4_park_HMASTER", {31'd0, HMASTER}, 32'd0);
    chk("t4_park_M0_HREADY", {31'd0, M0_HREADY}, 32'd1);
`else
    chk("t4_hold_HMASTER", {31'd0, HMASTER}, 32'd1);
    chk("t4_hold_M0_HREADY", {31'd0, M0_HREADY}, 32'd0);
`endif
    tick();
    mid();
    chk("t4_m0_HMASTER", {31'd0, HMASTER}, 32'd0);
    chk("t4_m0_HADDR", HADDR, 32'h0000_0080);
    chk("t4_m0_M0_HREADY", {31'd0, M0_HREADY}, 32'd1);
    tick();

    // Reset while M1 is granted mid-burst
    m0(IDLE, 32'h5555_0000, 1'b0);
    m1(NONSEQ, 32'h3000_0000, 1'b0);
    mid();
    tick();
    mid();
    chk("t5_pre_HMASTER", {31'd0, HMASTER}, 32'd1);
    tick();
    m1(SEQ, 32'h3000_0004, 1'b0);
    HRESETn = 1'b0;
    mid();
    chk("t5_burst_HMASTER", {31'd0, HMASTER}, 32'd1);
    tick();
    HRESETn = 1'b1;
    mid();
    chk("t5_rst_HMASTER", {31'd0, HMASTER}, 32'd0);
    chk("t5_rst_HADDR", HADDR, 32'h5555_0000);
    chk("t5_rst_HWDATA", HWDATA, 32'h0000_AAAA);
    chk("t5_rst_M1_HREADY", {31'd0, M1_HREADY}, 32'd0);
    tick();
    m1(IDLE, 32'h0, 1'b0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
